// File: rtl/coord_ratio_scaler_if.sv
// Request/result bundle between the numerator/denominator switch, the scaler
// and the remap address generator.
interface coord_ratio_scaler_if #(
  parameter int W = 7
);
  localparam int QW = 2 * W;

  logic          start;
  logic [W-1:0]  x_in;
  logic [W-1:0]  y_in;
  logic [W-1:0]  x_numer;
  logic [W-1:0]  x_denom;
  logic [W-1:0]  y_numer;
  logic [W-1:0]  y_denom;
  logic          ready;
  logic          valid;
  logic [QW-1:0] x_out;
  logic [QW-1:0] y_out;
  logic          x_div0;
  logic          y_div0;

  modport master (
    output start, x_in, y_in, x_numer, x_denom, y_numer, y_denom,
    input  ready, valid, x_out, y_out, x_div0, y_div0
  );

  modport slave (
    input  start, x_in, y_in, x_numer, x_denom, y_numer, y_denom,
    output ready, valid, x_out, y_out, x_div0, y_div0
  );
endinterface

// File: rtl/coord_ratio_scaler.sv
// Scales a coordinate pair by numer/denom per axis using one shared restoring divider (X then Y).
// Optional build macro COORD_ROUND_EN: round-to-nearest (ties up) instead of floor.
module coord_ratio_scaler #(
  parameter int W = 7
) (
  input logic                 clk,
  input logic                 reset,
  coord_ratio_scaler_if.slave bus
);
  localparam int QW = 2 * W;
  localparam int CW = $clog2(QW);

  typedef enum logic [2:0] {IDLE, LOAD, DIV_X, DIV_Y, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  x_in_q, x_in_d, y_in_q, y_in_d;
  logic [W-1:0]  x_num_q, x_num_d, x_den_q, x_den_d;
  logic [W-1:0]  y_num_q, y_num_d, y_den_q, y_den_d;
  logic [QW-1:0] num_q, num_d, py_q, py_d, quo_q, quo_d, xq_q, xq_d;
  logic [W:0]    rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
  logic          x_div0_q, x_div0_d, y_div0_q, y_div0_d;

  logic [QW-1:0] prod_x, prod_y, quo_nx;
  logic [W:0]    rem_sh, rem_nx, cur_den;
  logic          q_bit;

  always_comb begin
`ifdef COORD_ROUND_EN
    // half the denominator is zero when the denominator is zero, so div0 stays unbiased
    prod_x = QW'(x_in_q) * QW'(x_num_q) + QW'(x_den_q >> 1);
    prod_y = QW'(y_in_q) * QW'(y_num_q) + QW'(y_den_q >> 1);
`else
    prod_x = QW'(x_in_q) * QW'(x_num_q);
    prod_y = QW'(y_in_q) * QW'(y_num_q);
`endif
    cur_den = (state_q == DIV_Y) ? {1'b0, y_den_q} : {1'b0, x_den_q};
    rem_sh  = (rem_q << 1) | (W+1)'(num_q[QW-1]);
    q_bit   = (rem_sh >= cur_den);
    rem_nx  = q_bit ? (rem_sh - cur_den) : rem_sh;
    quo_nx  = {quo_q[QW-2:0], q_bit};
  end

  always_comb begin
    state_d  = state_q;
    x_in_d   = x_in_q;
    y_in_d   = y_in_q;
    x_num_d  = x_num_q;
    x_den_d  = x_den_q;
    y_num_d  = y_num_q;
    y_den_d  = y_den_q;
    num_d    = num_q;
    py_d     = py_q;
    quo_d    = quo_q;
    xq_d     = xq_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    x_out_d  = x_out_q;
    y_out_d  = y_out_q;
    x_div0_d = x_div0_q;
    y_div0_d = y_div0_q;

    if ((state_q == IDLE || state_q == DONE) && bus.start) begin
      x_in_d  = bus.x_in;
      y_in_d  = bus.y_in;
      x_num_d = bus.x_numer;
      x_den_d = bus.x_denom;
      y_num_d = bus.y_numer;
      y_den_d = bus.y_denom;
    end

    case (state_q)
      IDLE:  if (bus.start) state_d = LOAD;
      LOAD: begin
        num_d   = prod_x;
        py_d    = prod_y;
        rem_d   = '0;
        cnt_d   = CW'(QW - 1);
        state_d = DIV_X;
      end
      DIV_X, DIV_Y: begin
        num_d = num_q << 1;
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (state_q == DIV_X) begin
            xq_d    = quo_nx;
            num_d   = py_q;
            rem_d   = '0;
            cnt_d   = CW'(QW - 1);
            state_d = DIV_Y;
          end else begin
            x_div0_d = (x_den_q == '0);
            y_div0_d = (y_den_q == '0);
            x_out_d  = (x_den_q == '0) ? '1 : xq_q;
            y_out_d  = (y_den_q == '0) ? '1 : quo_nx;
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = bus.start ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      x_in_q   <= '0;
      y_in_q   <= '0;
      x_num_q  <= '0;
      x_den_q  <= '0;
      y_num_q  <= '0;
      y_den_q  <= '0;
      num_q    <= '0;
      py_q     <= '0;
      quo_q    <= '0;
      xq_q     <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      x_out_q  <= '0;
      y_out_q  <= '0;
      x_div0_q <= 1'b0;
      y_div0_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_in_q   <= x_in_d;
      y_in_q   <= y_in_d;
      x_num_q  <= x_num_d;
      x_den_q  <= x_den_d;
      y_num_q  <= y_num_d;
      y_den_q  <= y_den_d;
      num_q    <= num_d;
      py_q     <= py_d;
      quo_q    <= quo_d;
      xq_q     <= xq_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      x_out_q  <= x_out_d;
      y_out_q  <= y_out_d;
      x_div0_q <= x_div0_d;
      y_div0_q <= y_div0_d;
    end
  end

  assign bus.ready  = (state_q == IDLE) || (state_q == DONE);
  assign bus.valid  = (state_q == DONE);
  assign bus.x_out  = x_out_q;
  assign bus.y_out  = y_out_q;
  assign bus.x_div0 = x_div0_q;
  assign bus.y_div0 = y_div0_q;
endmodule
